// File: rtl/score_display_pkg.sv
// Shared types and constants for the sequential score display driver.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
//
// Contents: the FSM state enum, the seven-segment glyphs (bit 0 = a, bit 6 = g,
// active-high), a glyph lookup and a power-of-ten helper for the overflow limit.
package score_display_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    // Non-decimal codes (10..15) render as dark.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // 10^n as a 64-bit constant; used at elaboration for the saturation limit.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction step: adds 3 to a BCD nibble that is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: nib_i - BCD nibble before the shift; nib_o - corrected nibble.
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule

// File: rtl/seven_seg_decoder_bus.sv
// One-digit BCD to seven-segment decoder with an output enable.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: D - BCD digit; En - enable, segments all off when low;
//        Seg - segments a..g on bits 0..6, active-high.
module seven_seg_decoder_bus
    import score_display_pkg::*;
(
    input  logic [3:0] D,
    input  logic       En,
    output logic [6:0] Seg
);

    assign Seg = En ? seg_enc(D) : 7'h00;

endmodule

// File: rtl/score_display_seq.sv
// Serial binary-to-decimal score display driver (double-dabble, 1 bit/clock).
// Latency: Load accepted at edge t -> Done and new Segments in cycle t+WIDTH+2.
// Backpressure: Load outside IDLE is dropped (Busy high); nothing is queued.
//
// Ports: Clock, CLRN (async active-low reset), X (score, sampled on accepted
//        Load), Load, Display (combinational blank-all), Busy, Done (1-cycle
//        pulse on display update), Overflow (committed value saturated),
//        Segments (7 bits per digit, digit 0 in the low bits).
module score_display_seq
    import score_display_pkg::*;
#(
    parameter int WIDTH    = 13,
    parameter int DIGITS   = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  Clock,
    input  logic                  CLRN,
    input  logic [WIDTH-1:0]      X,
    input  logic                  Load,
    input  logic                  Display,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Overflow,
    output logic [7*DIGITS-1:0]   Segments
);

    localparam int          BW    = 4 * DIGITS;
    localparam int          CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;    // binary bits still to shift in
    logic [WIDTH-1:0]   x_q, x_d;        // captured score for the overflow test
    logic [BW-1:0]      bcd_q, bcd_d;    // working BCD accumulator
    logic [BW-1:0]      bcd_adj;         // accumulator after add-3 correction
    logic [BW-1:0]      disp_q, disp_d;  // digits currently displayed
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [DIGITS-1:0]  blank;

    // Per-nibble add-3 correction, applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (bcd_q[4*g +: 4]),
            .nib_o (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        x_d     = x_q;
        bcd_d   = bcd_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Load) begin
                    bin_d   = X;
                    x_d     = X;
                    bcd_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[BW-2:0], bin_q, 1'b0};
                if (cnt_q == '0) begin
                    state_d = S_COMMIT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_COMMIT: begin
                // Out-of-range scores saturate to all nines; the accumulator
                // has lost its top digits by then and is not meaningful.
                if (64'(x_q) >= LIMIT) begin
                    disp_d = {DIGITS{4'h9}};
                    ovf_d  = 1'b1;
                end else begin
                    disp_d = bcd_q;
                    ovf_d  = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            x_q     <= '0;
            bcd_q   <= '0;
            disp_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            x_q     <= x_d;
            bcd_q   <= bcd_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Leading-zero blanking: digit i (i > 0) goes dark when it and every
    // digit above it are zero. Never applied to a saturated display.
    always_comb begin
        logic hi_zero;
        blank   = '0;
        hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero  = hi_zero && (disp_q[4*i +: 4] == 4'd0);
            blank[i] = BLANK_LZ && !ovf_q && hi_zero;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seven_seg_decoder_bus u_dec (
            .D   (disp_q[4*g +: 4]),
            .En  (Display & ~blank[g]),
            .Seg (Segments[7*g +: 7])
        );
    end

    assign Busy     = (state_q != S_IDLE);
    assign Done     = done_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_score_display_seq.sv
// Self-checking bench for score_display_seq: a 4-digit and a 3-digit instance
// share all inputs; a scoreboard of loaded scores is checked on every Done.
module tb_score_display_seq;

    localparam int W   = 13;
    localparam int LAT = W + 2;

    logic          Clock;
    logic          CLRN;
    logic [W-1:0]  X;
    logic          Load;
    logic          Display;
    logic          Busy4, Done4, Ovf4;
    logic [27:0]   Seg4;
    logic          Busy3, Done3, Ovf3;
    logic [20:0]   Seg3;

    int n_cmp = 0;
    int n_err = 0;
    int sb_q[$];

    score_display_seq #(.WIDTH(W), .DIGITS(4), .BLANK_LZ(1'b1)) dut4 (
        .Clock(Clock), .CLRN(CLRN), .X(X), .Load(Load), .Display(Display),
        .Busy(Busy4), .Done(Done4), .Overflow(Ovf4), .Segments(Seg4)
    );

    score_display_seq #(.WIDTH(W), .DIGITS(3), .BLANK_LZ(1'b1)) dut3 (
        .Clock(Clock), .CLRN(CLRN), .X(X), .Load(Load), .Display(Display),
        .Busy(Busy3), .Done(Done3), .Overflow(Ovf3), .Segments(Seg3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic bit model_ovf(input int v, input int nd);
        int p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        return v >= p;
    endfunction

    // Reference display: decimal digits by division, saturation, blanking.
    function automatic logic [27:0] model_seg(input int v, input int nd, input bit disp);
        logic [27:0] s;
        int          div;
        int          d;
        bit          ovf;
        bit          blk;
        s   = '0;
        div = 1;
        ovf = model_ovf(v, nd);
        for (int i = 0; i < nd; i++) begin
            d   = ovf ? 9 : (v / div) % 10;
            blk = !ovf && (i > 0) && (v < div);
            if (disp && !blk) s[7*i +: 7] = enc(d);
            div = div * 10;
        end
        return s;
    endfunction

    // Scoreboard checker: every Done must match the oldest accepted score.
    always @(negedge Clock) begin
        int v;
        if (CLRN && Done4) begin
            if (sb_q.size() == 0) begin
                chk_eq("spurious_done", 64'(Done4), 64'd0);
            end else begin
                v = sb_q.pop_front();
                chk_eq($sformatf("seg4_%0d", v), 64'(Seg4), 64'(model_seg(v, 4, Display)));
                chk_eq($sformatf("ovf4_%0d", v), 64'(Ovf4), 64'(model_ovf(v, 4)));
                chk_eq($sformatf("seg3_%0d", v), 64'({7'h00, Seg3}), 64'(model_seg(v, 3, Display)));
                chk_eq($sformatf("ovf3_%0d", v), 64'(Ovf3), 64'(model_ovf(v, 3)));
                chk_eq($sformatf("done3_%0d", v), 64'(Done3), 64'd1);
            end
        end
    end

    // Holds Load for exactly one rising edge; acc says whether it will be taken.
    task automatic do_load(input int v, input bit acc);
        X    = W'(v);
        Load = 1'b1;
        if (acc) sb_q.push_back(v);
        @(posedge Clock);
        #1;
        Load = 1'b0;
    endtask

    task automatic wait_done(output int busy, output int lat);
        bit got;
        busy = 0;
        lat  = 0;
        got  = 1'b0;
        for (int i = 0; i < 4 * LAT; i++) begin
            @(negedge Clock);
            lat++;
            if (Done4) begin
                got = 1'b1;
                break;
            end
            if (Busy4) busy++;
        end
        if (!got) chk_eq("done_timeout", 64'(Done4), 64'd1);
    endtask

    task automatic run(input int v);
        int b, l;
        do_load(v, 1'b1);
        wait_done(b, l);
    endtask

    initial begin
        int b, l;
        CLRN    = 1'b0;
        Load    = 1'b0;
        X       = '0;
        Display = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        chk_eq("rst_busy", 64'(Busy4), 64'd0);
        chk_eq("rst_done", 64'(Done4), 64'd0);
        chk_eq("rst_ovf", 64'(Ovf4), 64'd0);
        chk_eq("rst_seg4", 64'(Seg4), 64'(model_seg(0, 4, 1'b1)));
        chk_eq("rst_seg3", 64'({7'h00, Seg3}), 64'(model_seg(0, 3, 1'b1)));
        CLRN = 1'b1;
        @(posedge Clock);
        #1;

        // Latency and Busy window for a plain conversion.
        do_load(1234, 1'b1);
        wait_done(b, l);
        chk_eq("busy_cycles", 64'(b), 64'(W + 1));
        chk_eq("latency", 64'(l), 64'(LAT));

        // Display gating is combinational and leaves the display register intact.
        @(posedge Clock);
        #1;
        Display = 1'b0;
        #1;
        chk_eq("disp_off4", 64'(Seg4), 64'(model_seg(1234, 4, 1'b0)));
        chk_eq("disp_off3", 64'({7'h00, Seg3}), 64'(model_seg(1234, 3, 1'b0)));
        Display = 1'b1;
        #1;
        chk_eq("disp_on4", 64'(Seg4), 64'(model_seg(1234, 4, 1'b1)));

        run(7);
        run(0);
        run(8191);
        run(42);
        run(1000);
        run(999);

        // A Load during the conversion is dropped; a Load in the Done cycle is taken.
        do_load(1234, 1'b1);
        repeat (3) @(posedge Clock);
        #1;
        do_load(999, 1'b0);
        wait_done(b, l);
        do_load(999, 1'b1);
        wait_done(b, l);
        chk_eq("done_cycle_lat", 64'(l), 64'(LAT));

        for (int i = 0; i < 4; i++) run(int'($urandom_range(8191, 0)));

        // Asynchronous reset in the middle of a conversion.
        do_load(4321, 1'b1);
        repeat (4) @(posedge Clock);
        #1;
        CLRN = 1'b0;
        sb_q.delete();
        #1;
        chk_eq("abort_busy", 64'(Busy4), 64'd0);
        chk_eq("abort_done", 64'(Done4), 64'd0);
        chk_eq("abort_seg4", 64'(Seg4), 64'(model_seg(0, 4, 1'b1)));
        chk_eq("abort_ovf", 64'(Ovf4), 64'd0);
        repeat (2) @(posedge Clock);
        #1;
        CLRN = 1'b1;
        repeat (LAT + 5) @(posedge Clock);
        #1;
        chk_eq("abort_idle", 64'(Busy4), 64'd0);
        run(5);

        repeat (LAT + 5) @(posedge Clock);
        chk_eq("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
